// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory, buffers the returned word until the
// IF/ID register accepts it, and applies EX-stage redirects.
//
// Handshake: imem_req is a request strobe sampled by memory in any cycle it is
// high; exactly one imem_rvalid pulse answers each request, one or more cycles
// later. On the pipeline side, a word is transferred in a cycle where
// if_valid=1 and stall=0; while stall=1 the presented word is held unchanged.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [1:0]      dbg_state,
  output logic            dbg_drop,
  output logic            dbg_proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] instr_buf, instr_buf_n;
  logic            drop, drop_n;
  logic [XLEN-1:0] redirect_tgt;

  // Redirect targets are word aligned; the low two bits are cleared.
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      instr_buf <= '0;
      drop      <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr_buf <= instr_buf_n;
      drop      <= drop_n;
    end
  end

  // Next-state logic: redirect has priority over everything except in IDLE,
  // where it only preloads the pc. drop marks a response that belongs to a
  // fetch already abandoned by a redirect.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    instr_buf_n = instr_buf;
    drop_n      = drop;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (redirect_valid) pc_n = redirect_tgt;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_n    = redirect_tgt;
          state_n = S_REQ;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_tgt;
          if (imem_rvalid) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            instr_buf_n = imem_rdata;
            state_n     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_tgt;
          state_n = S_REQ;
        end else if (!stall) begin
          pc_n    = pc + XLEN'(4);
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs: a redirect suppresses both the request and the valid word.
  always_comb begin
    imem_req      = (state == S_REQ) && !redirect_valid;
    imem_addr     = pc;
    if_valid      = (state == S_HOLD) && !redirect_valid;
    if_instr      = instr_buf;
    if_pc         = pc;
    if_pc_plus4   = pc + XLEN'(4);
    dbg_state     = state;
    dbg_drop      = drop;
    dbg_proto_err = imem_rvalid && (state != S_WAIT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model and a
// scoreboard holding expected fetch addresses and expected delivered words.
module tb_fetch_unit;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [1:0]  dbg_state;
  logic        dbg_drop;
  logic        dbg_proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] req_exp_q[$];
  logic [63:0] out_exp_q[$];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .dbg_state(dbg_state), .dbg_drop(dbg_drop),
    .dbg_proto_err(dbg_proto_err)
  );

  // Clock and cycle counter (cycle 0 is the first cycle after reset release).
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2008_0005;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: request seen at the clock edge, response pulse lat cycles later.
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  always @(posedge clk) begin
    if (!rst && imem_req) begin
      pend_cnt  = lat;
      pend_addr = imem_addr;
    end
  end
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur, expected within budget (cycle %0d)", name, cyc);
  endtask

  task automatic push_req(input logic [31:0] a);
    req_exp_q.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] a);
    out_exp_q.push_back({a, mem_word(a)});
  endtask

  // Monitor: every request and every presented word is checked against the queues.
  logic [31:0] mon_req;
  logic [63:0] mon_out;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (imem_req) begin
        if (req_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL req_unexpected: got request addr %h, expected no request", imem_addr);
        end else begin
          mon_req = req_exp_q.pop_front();
          check("req_addr", imem_addr, mon_req);
        end
      end
      if (if_valid) begin
        if (out_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: got valid pc %h, expected no valid", if_pc);
        end else begin
          mon_out = out_exp_q[0];
          check("out_pc", if_pc, mon_out[63:32]);
          check("out_instr", if_instr, mon_out[31:0]);
          check("out_pc_plus4", if_pc_plus4, mon_out[63:32] + 32'd4);
          if (!stall) void'(out_exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks; all are entered and left one time unit after a falling edge.
  task automatic do_reset(input int l);
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    lat = l;
    req_exp_q.delete();
    out_exp_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (dbg_state == s) return;
    end
    timeout("wait_state");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (if_valid) return;
    end
    timeout("wait_valid");
  endtask

  task automatic wait_rvalid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (imem_rvalid) return;
    end
    timeout("wait_rvalid");
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (req_exp_q.size() == 0 && out_exp_q.size() == 0) return;
    end
    timeout("wait_empty");
  endtask

  initial begin
    // Reset values
    @(negedge clk); #2;
    check("rst_imem_req", imem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_pc", if_pc, 32'h0000_3000);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc_plus4", if_pc_plus4, 32'h0000_3004);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_drop", dbg_drop, 0);

    // Latency 1, no stall: one word every 3 cycles
    do_reset(1);
    push_req(32'h3000); push_req(32'h3004); push_req(32'h3008);
    push_out(32'h3000); push_out(32'h3004); push_out(32'h3008);
    @(negedge clk); #2;
    check("s1_first_req", imem_req, 1);
    check("s1_first_req_cyc", cyc, 1);
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      check("s1_valid_cyc", cyc, 3 + 3 * i);
    end
    wait_empty();

    // Stall held four cycles in HOLD
    do_reset(1);
    stall = 1'b1;
    push_req(32'h3000); push_req(32'h3004);
    push_out(32'h3000); push_out(32'h3004);
    wait_valid();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #2;
      check("s2_hold_valid", if_valid, 1);
      check("s2_hold_noreq", imem_req, 0);
      check("s2_hold_instr", if_instr, 32'h2008_0005);
    end
    @(negedge clk); #1;
    stall = 1'b0;
    #1 check("s2_release_valid", if_valid, 1);
    wait_empty();

    // Back-to-back redirects during WAIT, latency 3; the last target wins
    do_reset(3);
    push_req(32'h3000); push_req(32'h4000);
    push_out(32'h4000);
    wait_state(S_WAIT);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4100;
    #1 check("s3_redir_noreq", imem_req, 0);
    @(negedge clk); #1;
    redirect_pc = 32'h0000_4002;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    check("s3_drop_set", dbg_drop, 1);
    check("s3_stale_rvalid", imem_rvalid, 1);
    check("s3_stale_novalid", if_valid, 0);
    wait_empty();

    // Redirect in the same cycle as the response
    do_reset(2);
    push_req(32'h3000); push_req(32'h5000);
    push_out(32'h5000);
    wait_rvalid();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_5000;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1 check("s4a_drop_clear", dbg_drop, 0);
    wait_empty();

    // Redirect during HOLD with stall asserted
    do_reset(1);
    stall = 1'b1;
    push_req(32'h3000); push_req(32'h6000);
    push_out(32'h6000);
    wait_state(S_HOLD);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_6001;
    #1 check("s4b_flush_valid", if_valid, 0);
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    stall = 1'b0;
    wait_empty();

    // Reset in the middle of WAIT; the late response must be ignored
    do_reset(3);
    push_req(32'h3000); push_req(32'h3000);
    push_out(32'h3000);
    wait_state(S_WAIT);
    rst = 1'b1;
    #1;
    check("s5_rst_state", dbg_state, S_IDLE);
    check("s5_rst_noreq", imem_req, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("s5_late_rvalid_flag", dbg_proto_err, 1);
    check("s5_pc", imem_addr, 32'h0000_3000);
    wait_empty();

    // Redirect in IDLE to the top word; pc+4 wraps to zero
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    push_req(32'hFFFF_FFFC); push_req(32'h0000_0000);
    push_out(32'hFFFF_FFFC); push_out(32'h0000_0000);
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    wait_valid();
    check("s6_wrap_plus4", if_pc_plus4, 32'h0000_0000);
    wait_empty();

    // Redirect in REQ suppresses that request
    do_reset(1);
    push_req(32'h7000);
    push_out(32'h7000);
    wait_state(S_REQ);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_7000;
    #1 check("s7_redir_noreq", imem_req, 0);
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    wait_empty();

    rst = 1'b1;
    @(negedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
